// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller, parameter store and interval timer.
package traffic_pkg;

    localparam int VALUE_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } timer_state_e;

endpackage

// File: rtl/tick_divider.sv
// Clock-enable divider: counts 0..TICK_DIV-1 while enabled and flags the last count as a tick.
module tick_divider #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Seconds countdown: latches value on Start_Timer, decrements on each 1 Hz tick, pulses Expired at zero.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int VALUE_W  = traffic_pkg::VALUE_W
) (
    input  logic               clk,
    input  logic               Reset_Sync,
    input  logic               Start_Timer,
    input  logic [VALUE_W-1:0] value,
    output logic               Expired,
    output logic               Busy,
    output logic [VALUE_W-1:0] Remaining,
    output logic               One_Hz_En
);

    timer_state_e       state_q, state_d;
    logic [VALUE_W-1:0] rem_q, rem_d;
    logic               expired_q, expired_d;
    logic               busy_q, busy_d;
    logic               hz_q, hz_d;
    logic               tick;
    logic               counting;

    assign counting = (state_q == COUNT);

    // Divider is cleared on every start so a retrigger always begins a full second.
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (Reset_Sync),
        .clr  (Start_Timer || !counting),
        .en   (counting),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        expired_d = 1'b0;
        hz_d      = tick;
        if (Start_Timer) begin
            if (value != '0) begin
                state_d = COUNT;
                rem_d   = value;
            end else begin
                state_d   = IDLE;
                rem_d     = '0;
                expired_d = 1'b1;
            end
        end else if (counting && tick) begin
            if (rem_q <= VALUE_W'(1)) begin
                state_d   = IDLE;
                rem_d     = '0;
                expired_d = 1'b1;
            end else begin
                rem_d = rem_q - VALUE_W'(1);
            end
        end
        busy_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
            hz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
            hz_q      <= hz_d;
        end
    end

    assign Expired   = expired_q;
    assign Busy      = busy_q;
    assign Remaining = rem_q;
    assign One_Hz_En = hz_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a 4-cycle second.
module tb_interval_timer;

    localparam int TD = 4;
    localparam int VW = 4;

    logic          clk;
    logic          Reset_Sync;
    logic          Start_Timer;
    logic [VW-1:0] value;
    logic          Expired;
    logic          Busy;
    logic [VW-1:0] Remaining;
    logic          One_Hz_En;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int base;

    interval_timer #(
        .TICK_DIV (TD),
        .VALUE_W  (VW)
    ) dut (
        .clk         (clk),
        .Reset_Sync  (Reset_Sync),
        .Start_Timer (Start_Timer),
        .value       (value),
        .Expired     (Expired),
        .Busy        (Busy),
        .Remaining   (Remaining),
        .One_Hz_En   (One_Hz_En)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (Expired === 1'b1) exp_cnt = exp_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Returns just after the edge that samples the start (edge 0).
    task automatic start_t(input int v);
        @(negedge clk);
        Start_Timer = 1'b1;
        value = VW'(v);
        @(posedge clk);
        #1;
        Start_Timer = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        Reset_Sync  = 1'b1;
        Start_Timer = 1'b0;
        value       = '0;
        #12;
        check("rst_exp", int'(Expired), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_rem", int'(Remaining), 0);
        check("rst_hz", int'(One_Hz_En), 0);
        @(negedge clk);
        Reset_Sync = 1'b0;
        adv(2);

        // basic count of 4
        base = exp_cnt;
        start_t(4);
        check("b_rem0", int'(Remaining), 4);
        check("b_busy0", int'(Busy), 1);
        check("b_exp0", int'(Expired), 0);
        adv(3);
        check("b_rem3", int'(Remaining), 4);
        check("b_hz3", int'(One_Hz_En), 0);
        adv(1);
        check("b_rem4", int'(Remaining), 3);
        check("b_hz4", int'(One_Hz_En), 1);
        adv(1);
        check("b_hz5", int'(One_Hz_En), 0);
        adv(3);
        check("b_rem8", int'(Remaining), 2);
        adv(4);
        check("b_rem12", int'(Remaining), 1);
        check("b_exp12", int'(Expired), 0);
        adv(3);
        check("b_exp15", int'(Expired), 0);
        check("b_busy15", int'(Busy), 1);
        adv(1);
        check("b_rem16", int'(Remaining), 0);
        check("b_exp16", int'(Expired), 1);
        check("b_busy16", int'(Busy), 0);
        adv(1);
        check("b_exp17", int'(Expired), 0);
        check("b_hz17", int'(One_Hz_En), 0);
        adv(8);
        check("b_rem_hold", int'(Remaining), 0);
        check("b_pulses", exp_cnt - base, 1);

        // zero-length interval
        base = exp_cnt;
        start_t(0);
        check("z_exp0", int'(Expired), 1);
        check("z_busy0", int'(Busy), 0);
        check("z_rem0", int'(Remaining), 0);
        adv(1);
        check("z_exp1", int'(Expired), 0);
        check("z_busy1", int'(Busy), 0);
        adv(5);
        check("z_busy6", int'(Busy), 0);
        check("z_pulses", exp_cnt - base, 1);

        // retrigger: 6 at edge 0, 2 at edge 9
        base = exp_cnt;
        start_t(6);
        adv(8);
        check("r_rem8", int'(Remaining), 4);
        start_t(2);
        check("r_rem9", int'(Remaining), 2);
        adv(7);
        check("r_rem16", int'(Remaining), 1);
        check("r_exp16", int'(Expired), 0);
        adv(1);
        check("r_exp17", int'(Expired), 1);
        adv(8);
        check("r_exp25", int'(Expired), 0);
        check("r_pulses", exp_cnt - base, 1);

        // start coincident with final tick
        base = exp_cnt;
        start_t(1);
        adv(3);
        start_t(3);
        check("c_rem4", int'(Remaining), 3);
        check("c_exp4", int'(Expired), 0);
        check("c_busy4", int'(Busy), 1);
        adv(11);
        check("c_exp15", int'(Expired), 0);
        adv(1);
        check("c_exp16", int'(Expired), 1);
        adv(2);
        check("c_pulses", exp_cnt - base, 1);

        // value sampled only on start
        base = exp_cnt;
        start_t(3);
        adv(2);
        value = 4'd9;
        check("s_rem2", int'(Remaining), 3);
        adv(9);
        check("s_exp11", int'(Expired), 0);
        check("s_rem11", int'(Remaining), 1);
        adv(1);
        check("s_exp12", int'(Expired), 1);
        check("s_rem12", int'(Remaining), 0);
        adv(2);
        check("s_pulses", exp_cnt - base, 1);

        // asynchronous reset mid-count
        base = exp_cnt;
        start_t(4);
        adv(6);
        check("a_rem6", int'(Remaining), 3);
        Reset_Sync = 1'b1;
        #1;
        check("a_rem", int'(Remaining), 0);
        check("a_busy", int'(Busy), 0);
        check("a_exp", int'(Expired), 0);
        check("a_hz", int'(One_Hz_En), 0);
        adv(2);
        @(negedge clk);
        Reset_Sync = 1'b0;
        adv(20);
        check("a_busy_after", int'(Busy), 0);
        check("a_pulses", exp_cnt - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
